// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a first-word-fall-through
// receive FIFO, sticky line-error flags and a level interrupt.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the
// data bits and the parity_err output.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int DATA_BITS     = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int INT_THRESHOLD = 1,
  parameter bit PARITY_ODD    = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             uart_in,
  input  logic                             rd_en,
  output logic [DATA_BITS-1:0]             rd_data,
  output logic                             rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             frame_err,
  output logic                             overrun_err,
  input  logic                             err_clr,
`ifdef UART_RX_PARITY_EN
  output logic                             parity_err,
`endif
  output logic                             int0
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  logic                 sync1_q, sync2_q, armed_q;
  logic [1:0]           age_q;
  logic                 rx, start_edge;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_req, fe_set, tick_half, tick_full, word_bad;
  logic                 frame_err_q, overrun_err_q, int0_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d, pe_set, parity_err_q;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 empty, full, do_pop, do_push, ovr_set;

  // The synchroniser presets high, so the first two post-reset samples are not
  // real line values; armed_q only arms edge detection once a genuine high is
  // seen, which keeps a line held low across reset from looking like a start.
  assign rx         = sync2_q;
  assign start_edge = age_q[1] & armed_q & ~rx;
  assign tick_half  = (cnt_q == CNT_W'(HALF - 1));
  assign tick_full  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Line synchroniser and start-edge arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      age_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= uart_in;
      sync2_q <= sync1_q;
      age_q   <= {age_q[0], 1'b1};
      armed_q <= age_q[1] & rx;
    end
  end

  // Receive FSM and bit-timing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Deframing shift register; holds no control state, so it is not reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

`ifdef UART_RX_PARITY_EN
  assign word_bad = par_bad_q;
`else
  assign word_bad = 1'b0;
`endif

  // Next-state logic: sample mid-bit, LSB first, push on a good stop bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    fe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_set    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (start_edge) state_d = START;
      end
      START: begin
        if (tick_half) begin
          cnt_d   = '0;
          state_d = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_full) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          cnt_d   = '0;
          state_d = STOP;
          if (rx != ((^shift_q) ^ PARITY_ODD)) begin
            pe_set    = 1'b1;
            par_bad_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          cnt_d = '0;
          if (rx) begin
            push_req = ~word_bad;
            state_d  = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_req & (~full | do_pop);
  assign ovr_set = push_req & full & ~do_pop;

  // FIFO occupancy update.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy, sticky errors and registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      int0_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_d;
      frame_err_q   <= fe_set  | (frame_err_q   & ~err_clr);
      overrun_err_q <= ovr_set | (overrun_err_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= pe_set  | (parity_err_q  & ~err_clr);
      int0_q        <= (count_q >= CW'(INT_THRESHOLD)) | frame_err_q | overrun_err_q | parity_err_q;
`else
      int0_q        <= (count_q >= CW'(INT_THRESHOLD)) | frame_err_q | overrun_err_q;
`endif
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign rd_data     = empty ? '0 : mem[rd_ptr_q];
  assign rx_valid    = ~empty;
  assign fifo_count  = count_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign int0        = int0_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard testbench for uart_rx_fifo (default parameters). Parity
// scenarios are built in when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_in = 1'b1;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DB-1:0] rd_data;
  logic          rx_valid;
  logic [CW-1:0] fifo_count;
  logic          frame_err, overrun_err, int0;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [DB-1:0] exp_q[$];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH),
                 .INT_THRESHOLD(1), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .rd_en(rd_en),
    .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
    .frame_err(frame_err), .overrun_err(overrun_err), .err_clr(err_clr),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .int0(int0)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one frame; start bit, data LSB first, [parity], stop.
  task automatic send_frame(input logic [DB-1:0] data, input logic par_bit, input logic stop_bit);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      uart_in = data[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_in = par_bit;
    repeat (CPB) @(negedge clk);
`endif
    uart_in = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_in = 1'b1;
    repeat (4) @(negedge clk);
    tests_run += 6;
    if (rx_valid !== 1'b0)    begin tests_failed++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    if (fifo_count !== '0)    begin tests_failed++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    if (int0 !== 1'b0)        begin tests_failed++; $display("FAIL reset_int0 got %b want 0", int0); end
    if (frame_err !== 1'b0)   begin tests_failed++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    if (overrun_err !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun_err); end
    if (rd_data !== '0)       begin tests_failed++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    wait_valid(ok);
    tests_run += 4;
    if (!ok) begin tests_failed++; $display("FAIL single_valid timeout rx_valid=%b want 1", rx_valid); end
    if (rd_data !== exp_q[0]) begin tests_failed++; $display("FAIL single_data got %h want %h", rd_data, exp_q[0]); end
    if (fifo_count !== CW'(1)) begin tests_failed++; $display("FAIL single_count got %0d want 1", fifo_count); end
    if (int0 !== 1'b1) begin tests_failed++; $display("FAIL single_int0 got %b want 1", int0); end
    do_pop();
    void'(exp_q.pop_front());
    tests_run += 2;
    if (fifo_count !== '0) begin tests_failed++; $display("FAIL single_pop_count got %0d want 0", fifo_count); end
    @(negedge clk);
    if (int0 !== 1'b0) begin tests_failed++; $display("FAIL single_pop_int0 got %b want 0", int0); end
  endtask

  task automatic test_glitch();
    bit ok;
    uart_in = 1'b0;
    repeat (4) @(negedge clk);
    uart_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests_run += 3;
    if (fifo_count !== '0)  begin tests_failed++; $display("FAIL glitch_count got %0d want 0", fifo_count); end
    if (rx_valid !== 1'b0)  begin tests_failed++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL glitch_frame_err got %b want 0", frame_err); end
    // A clean frame right after shows the receiver went back to idle.
    send_frame(8'h5A, ^8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    wait_valid(ok);
    tests_run += 2;
    if (!ok) begin tests_failed++; $display("FAIL glitch_recover_valid timeout got %b want 1", rx_valid); end
    if (rd_data !== exp_q[0]) begin tests_failed++; $display("FAIL glitch_recover_data got %h want %h", rd_data, exp_q[0]); end
    do_pop();
    void'(exp_q.pop_front());
  endtask

  task automatic test_framing();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    tests_run += 3;
    if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL frame_err_set got %b want 1", frame_err); end
    if (fifo_count !== '0)  begin tests_failed++; $display("FAIL frame_count got %0d want 0", fifo_count); end
    if (int0 !== 1'b1)      begin tests_failed++; $display("FAIL frame_int0 got %b want 1", int0); end
    uart_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests_run += 1;
    if (fifo_count !== '0)  begin tests_failed++; $display("FAIL frame_spurious_count got %0d want 0", fifo_count); end
    pulse_clr();
    tests_run += 2;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL frame_clr got %b want 0", frame_err); end
    @(negedge clk);
    if (int0 !== 1'b0)      begin tests_failed++; $display("FAIL frame_clr_int0 got %b want 0", int0); end
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] v;
    for (int i = 0; i < 3; i++) begin
      v = DB'($urandom_range(0, 255));
      send_frame(v, ^v, 1'b1);
      exp_q.push_back(v);
    end
    tests_run += 1;
    if (fifo_count !== CW'(3)) begin tests_failed++; $display("FAIL b2b_count got %0d want 3", fifo_count); end
    for (int i = 0; i < 3; i++) begin
      tests_run += 1;
      if (exp_q.size() == 0 || rd_data !== exp_q[0]) begin
        tests_failed++; $display("FAIL b2b_data[%0d] got %h want %h", i, rd_data, exp_q[0]);
      end
      do_pop();
      void'(exp_q.pop_front());
    end
    tests_run += 1;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_overrun();
    logic [DB-1:0] v;
    for (int i = 1; i <= 9; i++) begin
      v = DB'(i);
      send_frame(v, ^v, 1'b1);
      if (exp_q.size() < DEPTH) exp_q.push_back(v);
    end
    tests_run += 2;
    if (fifo_count !== CW'(DEPTH)) begin tests_failed++; $display("FAIL ovr_count got %0d want %0d", fifo_count, DEPTH); end
    if (overrun_err !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b want 1", overrun_err); end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run += 1;
      if (exp_q.size() == 0 || rd_data !== exp_q[0]) begin
        tests_failed++; $display("FAIL ovr_data[%0d] got %h want %h", i, rd_data, exp_q[0]);
      end
      do_pop();
      void'(exp_q.pop_front());
    end
    tests_run += 1;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_empty got %b want 0", rx_valid); end
    pulse_clr();
    tests_run += 1;
    if (overrun_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_clr got %b want 0", overrun_err); end
    repeat (2) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    bit ok;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tests_run += 3;
    if (parity_err !== 1'b1) begin tests_failed++; $display("FAIL par_err_set got %b want 1", parity_err); end
    if (fifo_count !== '0)   begin tests_failed++; $display("FAIL par_count got %0d want 0", fifo_count); end
    if (int0 !== 1'b1)       begin tests_failed++; $display("FAIL par_int0 got %b want 1", int0); end
    pulse_clr();
    tests_run += 1;
    if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL par_clr got %b want 0", parity_err); end
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back(8'h07);
    wait_valid(ok);
    tests_run += 2;
    if (!ok) begin tests_failed++; $display("FAIL par_good_valid timeout got %b want 1", rx_valid); end
    if (rd_data !== exp_q[0]) begin tests_failed++; $display("FAIL par_good_data got %h want %h", rd_data, exp_q[0]); end
    do_pop();
    void'(exp_q.pop_front());
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
